// File: rtl/fifo_tx_pkg.sv
// rtl/fifo_tx_pkg.sv - shared types and helpers for the FIFO-fed serial transmitter
//
// Contents:
//   state_e     : transmitter FSM states
//   IDLE_LEVEL  : level driven on the serial line when no bit is being sent
//   clog2()     : counter width helper, never returns less than 1
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Width needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period timer for the serial transmitter
//
// Ports:
//   clk      in  : clock, posedge
//   reset    in  : synchronous active-high reset
//   clear    in  : restart the bit period on the next cycle
//   bit_tick out : high on the last cycle of each CLKS_PER_BIT period
module baud_tick_gen
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick is a decode of the registered count, so it never depends on clear.
    assign bit_tick = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || bit_tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops bytes from a synchronous FIFO and sends them as UART frames
//
// Frame: start bit (low), DATA_W data bits LSB first, optional even parity,
// STOP_BITS stop bits (high). Every bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk         in  : clock, posedge
//   reset       in  : synchronous active-high reset, aborts any frame in flight
//   tx_en       in  : allows a new frame to start; a running frame always completes
//   fifo_empty  in  : FIFO empty flag (may lag the true fill level by one cycle)
//   fifo_data   in  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out : one-cycle pop request per frame
//   tx          out : serial line, idles high
//   busy        out : high whenever the FSM is not idle
//   frame_done  out : one-cycle pulse in the first idle cycle after a frame
module fifo_serial_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_CW = clog2(DATA_W + STOP_BITS);
    localparam logic [BIT_CW-1:0] LAST_DATA_BIT = BIT_CW'(DATA_W - 1);
    localparam logic [BIT_CW-1:0] LAST_STOP_BIT = BIT_CW'(STOP_BITS - 1);

    state_e              state_q;
    state_e              state_d;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_d;
    logic                parity_q;
    logic                parity_d;
    logic [BIT_CW-1:0]   bit_cnt_q;
    logic [BIT_CW-1:0]   bit_cnt_d;
    logic                frame_done_q;
    logic                frame_done_d;
    logic                bit_tick;
    logic                baud_clear;

    // Restarting the timer on every state change keeps each state's first
    // cycle aligned to count zero, so bit periods never drift.
    assign baud_clear = (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The empty flag is only looked at here, long after the
                // previous pop, so its one-cycle lag has already settled.
                if (tx_en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Read data is valid one cycle after the pop.
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                state_d  = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line level is a pure decode of registered state.
    always_comb begin
        tx = IDLE_LEVEL;
        case (state_q)
            START:   tx = ~IDLE_LEVEL;
            DATA:    tx = shift_q[0];
            PARITY:  tx = parity_q;
            default: tx = IDLE_LEVEL;
        endcase
    end

    assign fifo_rd_en = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - scoreboard bench for fifo_serial_tx (two parity/stop configurations)
module tb_fifo_serial_tx;

    localparam int CPB = 4;
    localparam int NL  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_en = 1'b0;
    logic [NL-1:0] fifo_empty = '1;
    logic [NL-1:0] fifo_rd_en;
    logic [NL-1:0] tx;
    logic [NL-1:0] busy;
    logic [NL-1:0] frame_done;
    logic [7:0]    fifo_data [NL] = '{default: 8'h00};

    // Lane 0: no parity, 1 stop bit. Lane 1: even parity, 2 stop bits.
    for (genvar g = 0; g < NL; g++) begin : lane
        fifo_serial_tx #(
            .DATA_W      (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (g),
            .STOP_BITS   (1 + g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .tx_en     (tx_en),
            .fifo_empty(fifo_empty[g]),
            .fifo_data (fifo_data[g]),
            .fifo_rd_en(fifo_rd_en[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .frame_done(frame_done[g])
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq    [NL][$];
    logic [7:0] exp_q [NL][$];

    int   cyc = 0;
    bit   coll [NL]     = '{default: 1'b0};
    bit   infl [NL]     = '{default: 1'b0};
    bit   bb   [NL]     = '{default: 1'b0};
    int   cnt  [NL]     = '{default: 0};
    int   since_rd [NL] = '{default: 1000};
    int   end_cyc [NL]  = '{default: 0};
    int   pops [NL]     = '{default: 0};
    int   frames [NL]   = '{default: 0};
    logic smp [NL][64];
    logic reset_prev = 1'b1;
    logic tx_en_prev = 1'b0;

    task automatic check(input int ln, input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s lane %0d: got %0h expected %0h at cycle %0d", name, ln, act, expv, cyc);
        end
    endtask

    function automatic int flen(input int l);
        return (1 + 8 + l + (1 + l)) * CPB;
    endfunction

    // Line level of bit slot k in a frame carrying byte b on lane l.
    function automatic logic exp_level(input int l, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (l == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // FIFO model: registered empty flag computed before the pop, so it lags by one cycle.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            fifo_empty[l] <= (fq[l].size() == 0);
            if (fifo_rd_en[l] && fq[l].size() > 0) begin
                fifo_data[l] <= fq[l].pop_front();
            end
        end
    end

    // Monitor: samples on the falling edge, rebuilds each frame and scores it.
    always @(negedge clk) begin
        logic [7:0] b;
        logic [7:0] dec;
        bit shape_ok;
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (reset_prev) begin
                check(l, "reset_outputs", {28'd0, tx[l], busy[l], fifo_rd_en[l], frame_done[l]}, 32'b1000);
                coll[l] = 1'b0;
                infl[l] = 1'b0;
                bb[l]   = 1'b0;
            end else begin
                if (fifo_rd_en[l]) begin
                    check(l, "rd_en_gate", {31'd0, tx_en_prev}, 32'd1);
                    check(l, "pop_nonempty", {31'd0, fq[l].size() > 0}, 32'd1);
                    check(l, "one_pop_per_frame", {31'd0, infl[l]}, 32'd0);
                    infl[l]     = 1'b1;
                    since_rd[l] = 0;
                    pops[l]++;
                end else begin
                    since_rd[l]++;
                end
                if (!coll[l]) begin
                    check(l, "frame_done_idle", {31'd0, frame_done[l]}, 32'd0);
                    if (tx[l] === 1'b0) begin
                        check(l, "start_latency", since_rd[l], 32'd2);
                        if (bb[l]) check(l, "b2b_gap", cyc - end_cyc[l], 32'd3);
                        bb[l]   = 1'b0;
                        coll[l] = 1'b1;
                        cnt[l]  = 0;
                    end
                end
                if (coll[l]) begin
                    if (cnt[l] < flen(l)) begin
                        smp[l][cnt[l]] = tx[l];
                        check(l, "busy_in_frame", {31'd0, busy[l]}, 32'd1);
                        check(l, "frame_done_early", {31'd0, frame_done[l]}, 32'd0);
                        cnt[l]++;
                    end else begin
                        check(l, "frame_end", {29'd0, tx[l], busy[l], frame_done[l]}, 32'b101);
                        check(l, "frame_expected", {31'd0, exp_q[l].size() > 0}, 32'd1);
                        if (exp_q[l].size() > 0) begin
                            b = exp_q[l].pop_front();
                            for (int i = 0; i < 8; i++) dec[i] = smp[l][(1 + i) * CPB + CPB / 2];
                            check(l, "frame_data", {24'd0, dec}, {24'd0, b});
                            shape_ok = 1'b1;
                            for (int k = 0; k < flen(l); k++) begin
                                if (smp[l][k] !== exp_level(l, b, k / CPB)) shape_ok = 1'b0;
                            end
                            check(l, "frame_shape", {31'd0, shape_ok}, 32'd1);
                            if (l == 1) check(l, "parity_bit", {31'd0, smp[l][9 * CPB + CPB / 2]}, {31'd0, ^b});
                            frames[l]++;
                        end
                        coll[l]    = 1'b0;
                        infl[l]    = 1'b0;
                        end_cyc[l] = cyc;
                        bb[l]      = !fifo_empty[l] && tx_en && !reset;
                    end
                end
                if (reset) begin
                    // The DUT aborts on the coming edge; a popped byte is lost.
                    if (infl[l] && exp_q[l].size() > 0) void'(exp_q[l].pop_front());
                    coll[l] = 1'b0;
                    infl[l] = 1'b0;
                    bb[l]   = 1'b0;
                end
            end
        end
        reset_prev = reset;
        tx_en_prev = tx_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        for (int l = 0; l < NL; l++) begin
            fq[l].push_back(b);
            exp_q[l].push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q[0].size() == 0 && exp_q[1].size() == 0 && busy == 2'b00 &&
                 !coll[0] && !coll[1]) && n < budget) begin
            tick(1);
            n++;
        end
        check(-1, "drain_in_time", {31'd0, n < budget}, 32'd1);
        tick(2);
    endtask

    initial begin
        int p0 [NL];
        int f0 [NL];

        // Reset and idle
        reset = 1'b1;
        tx_en = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        check(-1, "idle_tx", {30'd0, tx}, 32'b11);
        check(-1, "idle_busy", {30'd0, busy}, 32'b00);
        check(-1, "idle_pops", pops[0] + pops[1], 32'd0);

        // Single byte: tx falls three cycles after the empty flag falls
        tx_en = 1'b1;
        push(8'hA5);
        tick(3);
        check(0, "tx_high_in_wait", {31'd0, tx[0]}, 32'd1);
        tick(1);
        check(0, "tx_low_3_after_empty", {31'd0, tx[0]}, 32'd0);
        wait_drain(500);
        check(0, "single_pops", pops[0], 32'd1);

        // Back-to-back plus parity/stop frame
        for (int l = 0; l < NL; l++) p0[l] = pops[l];
        push(8'h00);
        push(8'hFF);
        push(8'h07);
        wait_drain(1000);
        for (int l = 0; l < NL; l++) begin
            check(l, "b2b_pops", pops[l] - p0[l], 32'd3);
            check(l, "b2b_fifo_empty", fq[l].size(), 32'd0);
        end

        // tx_en gating
        tx_en = 1'b0;
        for (int l = 0; l < NL; l++) p0[l] = pops[l];
        push(8'h5A);
        push(8'h81);
        push(8'h3E);
        tick(60);
        for (int l = 0; l < NL; l++) check(l, "gated_no_pop", pops[l] - p0[l], 32'd0);
        tx_en = 1'b1;
        tick(10);
        tx_en = 1'b0;
        tick(80);
        for (int l = 0; l < NL; l++) check(l, "gated_one_frame", pops[l] - p0[l], 32'd1);
        tx_en = 1'b1;
        wait_drain(1000);

        // Reset during data bit 3
        for (int l = 0; l < NL; l++) begin
            p0[l] = pops[l];
            f0[l] = frames[l];
        end
        push(8'h3C);
        push(8'hC3);
        tick(21);
        reset = 1'b1;
        tick(1);
        check(-1, "reset_tx_next", {30'd0, tx}, 32'b11);
        check(-1, "reset_busy_next", {30'd0, busy}, 32'b00);
        tick(1);
        reset = 1'b0;
        wait_drain(1000);
        for (int l = 0; l < NL; l++) begin
            check(l, "reset_pops", pops[l] - p0[l], 32'd2);
            check(l, "reset_frames", frames[l] - f0[l], 32'd1);
        end

        // Randomized traffic with tx_en toggling and occasional resets
        for (int i = 0; i < 30; i++) begin
            tx_en = ($urandom_range(0, 5) != 0);
            push(8'($urandom_range(0, 255)));
            tick($urandom_range(0, 50));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
            end
        end
        tx_en = 1'b1;
        wait_drain(8000);
        for (int l = 0; l < NL; l++) begin
            check(l, "final_fifo_empty", fq[l].size(), 32'd0);
            check(l, "final_scoreboard_empty", exp_q[l].size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Read-side consumer for the 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO's rd_en/empty/data interface and serializes it as an asynchronous UART-style frame on a single line.
- Frame order: start bit, data LSB first, optional parity, stop bit(s).
- Sits between the FIFO read port and the chip-level serial pin.

Parameters:
- DATA_W, 8, data bits per frame; must match the FIFO data width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- tx_en  in  1  when low, no new frame starts; a frame in flight completes.
- fifo_empty  in  1  FIFO empty flag; registered, may lag the true count by 1 cycle.
- fifo_data  in  DATA_W  FIFO read data; valid in the cycle after fifo_rd_en is sampled.
- fifo_rd_en  out  1  pop request, exactly one cycle per frame.
- tx  out  1  serial line; idles high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the final stop-bit cycle.

Behaviour:
- Reset (sync, high): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, bit/baud counters=0, shift register=0.
  - Reset asserted mid-frame aborts the frame; tx=1 on the next cycle.
  - The popped byte is lost; no further pop occurs until reset deasserts.
- All outputs are registered or Moore decodes of the state; there is no combinational path from inputs to outputs.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0 -> FETCH.
- FETCH (1 cycle): fifo_rd_en=1, tx=1 -> WAIT.
- WAIT (1 cycle): tx=1; shift_reg <= fifo_data; parity_bit <= ^fifo_data -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit, shifting right, DATA_W bits.
  - Afterwards -> PARITY if PARITY_EN, else STOP.
- PARITY: tx=parity_bit (even: total ones across data+parity is even) for CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done pulses in the cycle the state returns to IDLE.
- Latency: tx falls 3 cycles after the first IDLE cycle sampling fifo_empty=0 && tx_en=1.
- Frame length: (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames: minimum gap is 3 tx-high cycles beyond the stop bits (IDLE, FETCH, WAIT).
- Empty-flag lag: IDLE samples fifo_empty only on return from a full frame. The frame is at least 20 cycles, so the lagged flag is settled and the FIFO is never popped while empty.
- The baud counter restarts at 0 on every state entry; no drift accumulates across bits.
- tx_en dropping in FETCH or WAIT does not cancel the frame; the byte is already popped and is sent.
- fifo_data is sampled only in WAIT; changes in other states are ignored.

Decomposition:
- Package fifo_tx_pkg:
  - state enum {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP}
  - function clog2 for counter widths
  - localparam IDLE_LEVEL=1'b1
- Sub-module baud_tick_gen:
  - parameter CLKS_PER_BIT; inputs clk, reset, clear; output bit_tick.
  - Pulses bit_tick on the last cycle of each bit period; clear restarts the count.
- All remaining logic (FSM, shift register, bit counter) stays in fifo_serial_tx.

Test Plan:
- Reset and idle: reset=1 for 2 cycles, then FIFO empty -> tx=1, fifo_rd_en=0, busy=0, frame_done=0 indefinitely.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0: push 0xA5 -> one fifo_rd_en pulse; tx low 3 cycles after empty falls; bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; frame_done at cycle 40 of the frame.
- Back-to-back: push 0x00 then 0xFF -> exactly 2 rd_en pulses; 3 tx-high cycles between first stop end and second start; FIFO count ends at 0; no third pop.
- Parity/stop: PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit=1; stop high 8 cycles; frame 48 cycles.
- tx_en gating: tx_en=0 with 3 bytes queued -> no rd_en; tx_en=1 -> frames start; tx_en=0 mid-DATA -> current frame completes, no next pop.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 and busy=0 next cycle; after release, the next queued byte is sent cleanly.
